ipsxe_floating_point_fma_result_resolve_v1_0: RTL and testbench



---
 rtl/ipsxe_floating_point_fma_result_resolve_v1_0_pkg.sv | 28 ++
 rtl/ipsxe_floating_point_fma_result_resolve_v1_0_if.sv | 46 ++++
 rtl/ipsxe_floating_point_skid_fifo2_v1_0.sv | 70 +++++++
 rtl/ipsxe_floating_point_fma_result_resolve_v1_0.sv | 97 +++++++++
 tb/tb_ipsxe_floating_point_fma_result_resolve_v1_0.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ipsxe_floating_point_fma_result_resolve_v1_0_pkg.sv
// Shared floating-point constants for the FMA output stages: flag bit
// positions and builders for canonical qNaN, signed infinity and signed zero.
package ipsxe_floating_point_fma_result_resolve_v1_0_pkg;

  localparam int FLAG_W   = 3;
  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  // Exponent field all ones, positioned above the mantissa.
  function automatic logic [63:0] fp_exp_ones(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB only.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return fp_exp_ones(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] fp_inf(input int exp_w, input int man_w, input logic sign);
    return fp_exp_ones(exp_w, man_w) | ({63'd0, sign} << (exp_w + man_w));
  endfunction

  function automatic logic [63:0] fp_zero(input int exp_w, input int man_w, input logic sign);
    return {63'd0, sign} << (exp_w + man_w);
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_fma_result_resolve_v1_0_if.sv
// Bundle of the resolver's upstream flags/operands, downstream handshake
// and status outputs. The block is the slave; its driver is the master.
interface ipsxe_floating_point_fma_result_resolve_v1_0_if #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int CNT_WIDTH = 16
);
  localparam int W = 1 + EXP_WIDTH + MAN_WIDTH;

  logic                 i_aclken;
  logic                 i_valid;
  logic                 o_ready;
  logic                 i_set_result_0;
  logic                 i_set_result_c;
  logic                 i_set_result_nan;
  logic                 i_set_result_pinf;
  logic                 i_set_result_ninf;
  logic                 i_invalid_op;
  logic                 i_zero_sign;
  logic [W-1:0]         i_c;
  logic [W-1:0]         i_dp_result;
  logic                 i_dp_ovf;
  logic                 i_dp_unf;
  logic                 o_valid;
  logic                 i_ready;
  logic [W-1:0]         o_result;
  logic [2:0]           o_flags;
  logic                 i_status_clr;
  logic [2:0]           o_status;
  logic [CNT_WIDTH-1:0] o_invalid_cnt;

  modport slave (
    input  i_aclken, i_valid, i_set_result_0, i_set_result_c, i_set_result_nan,
           i_set_result_pinf, i_set_result_ninf, i_invalid_op, i_zero_sign,
           i_c, i_dp_result, i_dp_ovf, i_dp_unf, i_ready, i_status_clr,
    output o_ready, o_valid, o_result, o_flags, o_status, o_invalid_cnt
  );

  modport master (
    output i_aclken, i_valid, i_set_result_0, i_set_result_c, i_set_result_nan,
           i_set_result_pinf, i_set_result_ninf, i_invalid_op, i_zero_sign,
           i_c, i_dp_result, i_dp_ovf, i_dp_unf, i_ready, i_status_clr,
    input  o_ready, o_valid, o_result, o_flags, o_status, o_invalid_cnt
  );

endinterface

// File: rtl/ipsxe_floating_point_skid_fifo2_v1_0.sv
// Two-entry valid/ready buffer with fully registered handshake outputs.
// A full buffer does not accept in the same cycle as a pop.
module ipsxe_floating_point_skid_fifo2_v1_0 #(
  parameter int DATA_W = 35
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic [1:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              push, pop;

  // Occupancy bookkeeping and entry shifting for push/pop combinations.
  always_comb begin
    push   = in_valid & ready_q & en;
    pop    = valid_q & out_ready & en;
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, pop})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
      end
      2'b01: begin
        cnt_d  = cnt_q - 2'd1;
        head_d = tail_q;
      end
      // Simultaneous push/pop only happens with one entry held.
      2'b11:   head_d = in_data;
      default: ;
    endcase
    ready_d = (cnt_d != 2'd2);
    valid_d = (cnt_d != 2'd0);
  end

  // Buffer state registers; reset empties the buffer and zeroes the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = head_q;

endmodule

// File: rtl/ipsxe_floating_point_fma_result_resolve_v1_0.sv
// FMA output resolver: overrides the datapath result with special-case
// values by priority, raises exception flags, buffers results and keeps
// sticky status plus a saturating invalid-result counter.
module ipsxe_floating_point_fma_result_resolve_v1_0
  import ipsxe_floating_point_fma_result_resolve_v1_0_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int CNT_WIDTH = 16
) (
  input logic i_clk,
  input logic i_rst,
  ipsxe_floating_point_fma_result_resolve_v1_0_if.slave bus
);

  localparam int W = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_WIDTH, MAN_WIDTH));

  logic [W-1:0]         res_word;
  logic [FLAG_W-1:0]    res_flags;
  logic [W+FLAG_W-1:0]  head_data;
  logic [FLAG_W-1:0]    head_flags;
  logic                 pop;
  logic [FLAG_W-1:0]    status_q, status_d;
  logic [CNT_WIDTH-1:0] inv_cnt_q, inv_cnt_d, cnt_base;

  // Priority override of the datapath result; only the winning case flags.
  always_comb begin
    res_word  = bus.i_dp_result;
    res_flags = '0;
    if (bus.i_set_result_nan) begin
      res_word            = QNAN;
      res_flags[FLAG_INV] = bus.i_invalid_op;
    end else if (bus.i_set_result_pinf) begin
      res_word = W'(fp_inf(EXP_WIDTH, MAN_WIDTH, 1'b0));
    end else if (bus.i_set_result_ninf) begin
      res_word = W'(fp_inf(EXP_WIDTH, MAN_WIDTH, 1'b1));
    end else if (bus.i_set_result_0) begin
      res_word = W'(fp_zero(EXP_WIDTH, MAN_WIDTH, bus.i_zero_sign));
    end else if (bus.i_set_result_c) begin
      res_word = bus.i_c;
    end else if (bus.i_dp_ovf) begin
      res_word            = W'(fp_inf(EXP_WIDTH, MAN_WIDTH, bus.i_dp_result[W-1]));
      res_flags[FLAG_OVF] = 1'b1;
    end else if (bus.i_dp_unf) begin
      res_word            = W'(fp_zero(EXP_WIDTH, MAN_WIDTH, bus.i_dp_result[W-1]));
      res_flags[FLAG_UNF] = 1'b1;
    end
  end

  ipsxe_floating_point_skid_fifo2_v1_0 #(
    .DATA_W(W + FLAG_W)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .en       (bus.i_aclken),
    .in_valid (bus.i_valid),
    .in_ready (bus.o_ready),
    .in_data  ({res_word, res_flags}),
    .out_valid(bus.o_valid),
    .out_ready(bus.i_ready),
    .out_data (head_data)
  );

  assign head_flags    = head_data[FLAG_W-1:0];
  assign bus.o_result  = head_data[W+FLAG_W-1:FLAG_W];
  assign bus.o_flags   = head_flags;
  assign bus.o_status  = status_q;
  assign bus.o_invalid_cnt = inv_cnt_q;

  // Sticky status and invalid counter; a clear loses to a same-cycle pop.
  always_comb begin
    pop       = bus.o_valid & bus.i_ready & bus.i_aclken;
    status_d  = status_q;
    inv_cnt_d = inv_cnt_q;
    cnt_base  = inv_cnt_q;
    if (bus.i_aclken) begin
      cnt_base  = bus.i_status_clr ? '0 : inv_cnt_q;
      status_d  = (bus.i_status_clr ? '0 : status_q) | (pop ? head_flags : '0);
      inv_cnt_d = cnt_base;
      if (pop && head_flags[FLAG_INV] && (cnt_base != '1))
        inv_cnt_d = cnt_base + CNT_WIDTH'(1);
    end
  end

  // Status registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      status_q  <= '0;
      inv_cnt_q <= '0;
    end else begin
      status_q  <= status_d;
      inv_cnt_q <= inv_cnt_d;
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_fma_result_resolve_v1_0.sv
// Directed bench for the FMA result resolver. A second instance with a
// 2-bit invalid counter shares the same stimulus to exercise saturation.
module tb_ipsxe_floating_point_fma_result_resolve_v1_0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ipsxe_floating_point_fma_result_resolve_v1_0_if #(.EXP_WIDTH(8), .MAN_WIDTH(23), .CNT_WIDTH(16)) ifa ();
  ipsxe_floating_point_fma_result_resolve_v1_0_if #(.EXP_WIDTH(8), .MAN_WIDTH(23), .CNT_WIDTH(2))  ifb ();

  ipsxe_floating_point_fma_result_resolve_v1_0 #(.EXP_WIDTH(8), .MAN_WIDTH(23), .CNT_WIDTH(16)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(ifa.slave));
  ipsxe_floating_point_fma_result_resolve_v1_0 #(.EXP_WIDTH(8), .MAN_WIDTH(23), .CNT_WIDTH(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(ifb.slave));

  assign ifb.i_aclken          = ifa.i_aclken;
  assign ifb.i_valid           = ifa.i_valid;
  assign ifb.i_set_result_0    = ifa.i_set_result_0;
  assign ifb.i_set_result_c    = ifa.i_set_result_c;
  assign ifb.i_set_result_nan  = ifa.i_set_result_nan;
  assign ifb.i_set_result_pinf = ifa.i_set_result_pinf;
  assign ifb.i_set_result_ninf = ifa.i_set_result_ninf;
  assign ifb.i_invalid_op      = ifa.i_invalid_op;
  assign ifb.i_zero_sign       = ifa.i_zero_sign;
  assign ifb.i_c               = ifa.i_c;
  assign ifb.i_dp_result       = ifa.i_dp_result;
  assign ifb.i_dp_ovf          = ifa.i_dp_ovf;
  assign ifb.i_dp_unf          = ifa.i_dp_unf;
  assign ifb.i_ready           = ifa.i_ready;
  assign ifb.i_status_clr      = ifa.i_status_clr;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // flags order: {nan, pinf, ninf, zero, c, invalid_op}
  typedef struct {
    logic [5:0]  f;
    logic        ovf;
    logic        unf;
    logic        zs;
    logic [31:0] c;
    logic [31:0] dp;
    logic [31:0] er;
    logic [2:0]  ef;
  } vec_t;

  vec_t vt[11];

  task automatic apply(input vec_t v);
    {ifa.i_set_result_nan, ifa.i_set_result_pinf, ifa.i_set_result_ninf,
     ifa.i_set_result_0, ifa.i_set_result_c, ifa.i_invalid_op} = v.f;
    ifa.i_dp_ovf    = v.ovf;
    ifa.i_dp_unf    = v.unf;
    ifa.i_zero_sign = v.zs;
    ifa.i_c         = v.c;
    ifa.i_dp_result = v.dp;
  endtask

  task automatic set_plain(input logic [31:0] dp);
    vec_t v;
    v = '{6'b000000, 1'b0, 1'b0, 1'b0, 32'h0, dp, dp, 3'b000};
    apply(v);
  endtask

  task automatic set_nan_inv();
    vec_t v;
    v = '{6'b100001, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h7FC00000, 3'b100};
    apply(v);
  endtask

  initial begin
    vt[0]  = '{6'b110001, 1'b1, 1'b0, 1'b0, 32'h0,        32'h12345678, 32'h7FC00000, 3'b100};
    vt[1]  = '{6'b100000, 1'b0, 1'b0, 1'b0, 32'h0,        32'h12345678, 32'h7FC00000, 3'b000};
    vt[2]  = '{6'b011100, 1'b0, 1'b0, 1'b1, 32'h0,        32'h12345678, 32'h7F800000, 3'b000};
    vt[3]  = '{6'b001110, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'h3F800000, 32'hFF800000, 3'b000};
    vt[4]  = '{6'b000110, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'h3F800000, 32'h80000000, 3'b000};
    vt[5]  = '{6'b000010, 1'b1, 1'b0, 1'b0, 32'hC0490FDB, 32'h3F800000, 32'hC0490FDB, 3'b000};
    vt[6]  = '{6'b000000, 1'b1, 1'b1, 1'b0, 32'h0,        32'hBF812345, 32'hFF800000, 3'b010};
    vt[7]  = '{6'b000000, 1'b0, 1'b1, 1'b0, 32'h0,        32'h80000123, 32'h80000000, 3'b001};
    vt[8]  = '{6'b000000, 1'b0, 1'b0, 1'b0, 32'h0,        32'h40490FDB, 32'h40490FDB, 3'b000};
    vt[9]  = '{6'b000000, 1'b0, 1'b1, 1'b0, 32'h0,        32'h00000123, 32'h00000000, 3'b001};
    vt[10] = '{6'b000001, 1'b0, 1'b0, 1'b0, 32'h0,        32'h3F800000, 32'h3F800000, 3'b000};

    ifa.i_aclken = 1'b1;
    ifa.i_valid = 1'b0;
    ifa.i_ready = 1'b0;
    ifa.i_status_clr = 1'b0;
    set_plain(32'h0);
    step();
    step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst_valid",  ifa.o_valid, 0);
    chk("rst_ready",  ifa.o_ready, 1);
    chk("rst_result", ifa.o_result, 0);
    chk("rst_flags",  ifa.o_flags, 0);
    chk("rst_status", ifa.o_status, 0);
    chk("rst_cnt",    ifa.o_invalid_cnt, 0);

    // priority table, streamed with downstream always ready
    ifa.i_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      apply(vt[k]);
      ifa.i_valid = 1'b1;
      step();
      chk($sformatf("prio_valid_%0d", k),  ifa.o_valid, 1);
      chk($sformatf("prio_result_%0d", k), ifa.o_result, vt[k].er);
      chk($sformatf("prio_flags_%0d", k),  ifa.o_flags, vt[k].ef);
      chk($sformatf("prio_ready_%0d", k),  ifa.o_ready, 1);
    end
    ifa.i_valid = 1'b0;
    step();
    chk("prio_drained", ifa.o_valid, 0);
    chk("prio_status",  ifa.o_status, 3'b111);
    chk("prio_invcnt",  ifa.o_invalid_cnt, 1);

    // standalone clear
    ifa.i_status_clr = 1'b1;
    step();
    ifa.i_status_clr = 1'b0;
    chk("clr_status", ifa.o_status, 0);
    chk("clr_invcnt", ifa.o_invalid_cnt, 0);

    // backpressure: A, B accepted, C refused
    ifa.i_ready = 1'b0;
    set_plain(32'h11111111);
    ifa.i_valid = 1'b1;
    step();
    chk("bp_a_valid",  ifa.o_valid, 1);
    chk("bp_a_ready",  ifa.o_ready, 1);
    chk("bp_a_result", ifa.o_result, 32'h11111111);
    set_plain(32'h22222222);
    step();
    chk("bp_b_ready",  ifa.o_ready, 0);
    chk("bp_b_result", ifa.o_result, 32'h11111111);
    set_plain(32'h33333333);
    step();
    chk("bp_c_ready",  ifa.o_ready, 0);
    chk("bp_c_result", ifa.o_result, 32'h11111111);
    ifa.i_valid = 1'b0;
    ifa.i_ready = 1'b1;
    step();
    chk("bp_pop1_result", ifa.o_result, 32'h22222222);
    chk("bp_pop1_valid",  ifa.o_valid, 1);
    chk("bp_pop1_ready",  ifa.o_ready, 1);
    step();
    chk("bp_pop2_valid", ifa.o_valid, 0);

    // 100 back-to-back results, each one cycle after its push
    ifa.i_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      set_plain(32'h3F800000 + 32'(k));
      step();
      chk($sformatf("stream_valid_%0d", k),  ifa.o_valid, 1);
      chk($sformatf("stream_result_%0d", k), ifa.o_result, 32'h3F800000 + 32'(k));
      chk($sformatf("stream_ready_%0d", k),  ifa.o_ready, 1);
    end
    ifa.i_valid = 1'b0;
    step();
    chk("stream_drained", ifa.o_valid, 0);
    chk("stream_status",  ifa.o_status, 0);

    // three invalid results, then clear together with an overflow pop
    ifa.i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_nan_inv();
      step();
    end
    vt[0].f = 6'b000000;
    apply('{6'b000000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3F800000, 32'h7F800000, 3'b010});
    step();
    ifa.i_valid = 1'b0;
    chk("sticky_cnt3",    ifa.o_invalid_cnt, 3);
    chk("sticky_status1", ifa.o_status, 3'b100);
    chk("sticky_head",    ifa.o_result, 32'h7F800000);
    ifa.i_status_clr = 1'b1;
    step();
    ifa.i_status_clr = 1'b0;
    chk("sticky_clr_status", ifa.o_status, 3'b010);
    chk("sticky_clr_cnt",    ifa.o_invalid_cnt, 0);
    chk("sticky_clr_cnt_b",  ifb.o_invalid_cnt, 0);

    // clear with an invalid pop leaves the count at one
    set_nan_inv();
    ifa.i_valid = 1'b1;
    step();
    ifa.i_valid = 1'b0;
    ifa.i_status_clr = 1'b1;
    step();
    ifa.i_status_clr = 1'b0;
    chk("clrpop_status", ifa.o_status, 3'b100);
    chk("clrpop_cnt",    ifa.o_invalid_cnt, 1);
    ifa.i_status_clr = 1'b1;
    step();
    ifa.i_status_clr = 1'b0;

    // saturation of the 2-bit counter
    ifa.i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_nan_inv();
      step();
    end
    ifa.i_valid = 1'b0;
    step();
    chk("sat_cnt_a",  ifa.o_invalid_cnt, 5);
    chk("sat_cnt_b",  ifb.o_invalid_cnt, 3);
    chk("sat_status", ifa.o_status, 3'b100);

    // reset while full and with clock enable low
    ifa.i_ready = 1'b0;
    ifa.i_valid = 1'b1;
    set_plain(32'h44444444);
    step();
    set_plain(32'h55555555);
    step();
    ifa.i_valid = 1'b0;
    chk("full_ready", ifa.o_ready, 0);
    ifa.i_aclken = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifa.i_aclken = 1'b1;
    chk("mrst_valid",  ifa.o_valid, 0);
    chk("mrst_ready",  ifa.o_ready, 1);
    chk("mrst_status", ifa.o_status, 0);
    chk("mrst_result", ifa.o_result, 0);
    chk("mrst_cnt",    ifa.o_invalid_cnt, 0);

    // clock enable low freezes push, pop, clear and status
    set_nan_inv();
    ifa.i_valid = 1'b1;
    step();
    chk("ce_pre_valid", ifa.o_valid, 1);
    ifa.i_aclken = 1'b0;
    set_plain(32'h66666666);
    ifa.i_ready = 1'b1;
    ifa.i_status_clr = 1'b1;
    step();
    step();
    step();
    chk("ce_valid",  ifa.o_valid, 1);
    chk("ce_result", ifa.o_result, 32'h7FC00000);
    chk("ce_ready",  ifa.o_ready, 1);
    chk("ce_status", ifa.o_status, 0);
    chk("ce_cnt",    ifa.o_invalid_cnt, 0);
    ifa.i_valid = 1'b0;
    ifa.i_status_clr = 1'b0;
    ifa.i_aclken = 1'b1;
    step();
    chk("ce_rel_valid",  ifa.o_valid, 0);
    chk("ce_rel_status", ifa.o_status, 3'b100);
    chk("ce_rel_cnt",    ifa.o_invalid_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
